// File: rtl/dsp_threshold_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_thresh_pkg
//  Brief    : Shared op encodings, PIO register map and FSM states for the
//             DSP threshold controller.
//  Revision : 1.0  initial release
// ============================================================================
package dsp_thresh_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_VERIFY = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    function automatic logic [2:0] op_addr(input op_e op);
        case (op)
            OP_SET:   op_addr = ADDR_SET;
            OP_CLEAR: op_addr = ADDR_CLR;
            default:  op_addr = ADDR_DATA;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_threshold_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_threshold_ctrl_if
//  Brief    : Requester handshakes, PIO Avalon-MM bus and status of the
//             threshold controller; master = controller, slave = environment.
//  Revision : 1.0  initial release
// ============================================================================
interface dsp_threshold_ctrl_if #(
    parameter int DW = 32
);
    logic          req0_valid;
    logic [1:0]    req0_op;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [1:0]    req1_op;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic [2:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic [DW-1:0] shadow;
    logic          busy;
    logic          err_mismatch;
    logic          err_clr;

    modport master (
        input  req0_valid, req0_op, req0_data,
        output req0_ready,
        input  req1_valid, req1_op, req1_data,
        output req1_ready,
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata,
        output shadow, busy, err_mismatch,
        input  err_clr
    );

    modport slave (
        output req0_valid, req0_op, req0_data,
        input  req0_ready,
        output req1_valid, req1_op, req1_data,
        input  req1_ready,
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata,
        input  shadow, busy, err_mismatch,
        output err_clr
    );
endinterface
`default_nettype wire

// File: rtl/dsp_threshold_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin arbiter; the requester not granted last wins
//             a tie. Grant history advances only when a transaction completes.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] valid,
    input  wire logic       upd_en,
    input  wire logic       upd_id,
    output logic      [1:0] grant
);
    logic r_last_grant;

    // Resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (upd_en) begin
            r_last_grant <= upd_id;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = r_last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dsp_threshold_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_threshold_ctrl
//  Brief    : Shares the DSP threshold PIO between two requesters, issues the
//             matching PIO write, waits out a settle period and keeps a shadow.
//             Define THRESH_CTRL_VERIFY_EN to add a readback check state.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_threshold_ctrl
    import dsp_thresh_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int DW            = 32
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    dsp_threshold_ctrl_if.master bus
);
    localparam int            CW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] c_CNT_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef THRESH_CTRL_VERIFY_EN
    localparam state_e        c_POST_SETTLE = ST_VERIFY;
`else
    localparam state_e        c_POST_SETTLE = ST_ACK;
`endif

    state_e        r_state;
    state_e        w_state_nxt;
    op_e           r_op;
    logic [DW-1:0] r_data;
    logic          r_id;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_shadow;
    logic          r_err;
    logic [1:0]    w_grant;
    logic [1:0]    w_valid;
    logic          w_cs;
    logic          w_write_n;
    logic [2:0]    w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_ack;

    assign w_valid = {bus.req1_valid, bus.req0_valid};
    assign w_ack   = (r_state == ST_ACK);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (w_valid),
        .upd_en  (w_ack),
        .upd_id  (r_id),
        .grant   (w_grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus bus strobes; strobes are decoded from state so a reset
    // drops them in the same instant.
    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b0;
        w_write_n   = 1'b1;
        w_addr      = ADDR_DATA;
        w_wdata     = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (r_op != OP_NOP) begin
                    w_cs      = 1'b1;
                    w_write_n = 1'b0;
                    w_addr    = op_addr(r_op);
                    w_wdata   = r_data;
                end
                w_state_nxt = (SETTLE_CYCLES == 0) ? c_POST_SETTLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) w_state_nxt = c_POST_SETTLE;
            end
            ST_VERIFY: begin
                w_cs        = 1'b1;
                w_addr      = ADDR_DATA;
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= OP_WRITE;
            r_data   <= '0;
            r_id     <= 1'b0;
            r_cnt    <= '0;
            r_shadow <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_id   <= w_grant[1];
                        r_op   <= op_e'(w_grant[1] ? bus.req1_op : bus.req0_op);
                        r_data <= w_grant[1] ? bus.req1_data : bus.req0_data;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= c_CNT_LOAD;
                    case (r_op)
                        OP_WRITE: r_shadow <= r_data;
                        OP_SET:   r_shadow <= r_shadow | r_data;
                        OP_CLEAR: r_shadow <= r_shadow & ~r_data;
                        default:  r_shadow <= r_shadow;
                    endcase
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef THRESH_CTRL_VERIFY_EN
    // A fresh mismatch outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_VERIFY) && (bus.avm_readdata != r_shadow)) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused_verify;
    assign w_unused_verify = bus.err_clr ^ (^bus.avm_readdata);
    assign r_err           = 1'b0;
`endif

    assign bus.avm_chipselect = w_cs;
    assign bus.avm_write_n    = w_write_n;
    assign bus.avm_address    = w_addr;
    assign bus.avm_writedata  = w_wdata;
    assign bus.req0_ready     = w_ack & ~r_id;
    assign bus.req1_ready     = w_ack & r_id;
    assign bus.shadow         = r_shadow;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.err_mismatch   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_dsp_threshold_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dsp_threshold_ctrl
//  Brief    : Self-checking bench with a PIO model and a ready-driven
//             scoreboard; THRESH_CTRL_VERIFY_EN selects the readback build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_threshold_ctrl;
    import dsp_thresh_pkg::*;

    localparam int SETTLE = 4;
    localparam int DW     = 32;
`ifdef THRESH_CTRL_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif
    localparam int LAT = SETTLE + 1 + VX;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dsp_threshold_ctrl_if #(.DW(DW)) bus ();

    dsp_threshold_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .DW            (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // PIO register model with an optional stuck-at-0 on readback bit 0
    logic [DW-1:0] pio_q;
    logic          stuck_en = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio_q <= '0;
        else if (bus.avm_chipselect && !bus.avm_write_n) begin
            case (bus.avm_address)
                3'd0:    pio_q <= bus.avm_writedata;
                3'd4:    pio_q <= pio_q | bus.avm_writedata;
                3'd5:    pio_q <= pio_q & ~bus.avm_writedata;
                default: pio_q <= pio_q;
            endcase
        end
    end
    assign bus.avm_readdata = pio_q & ~{{(DW-1){1'b0}}, stuck_en};

    typedef struct {
        logic          id;
        logic          strobe;
        logic [2:0]    addr;
        logic [DW-1:0] data;
        logic [DW-1:0] shadow;
    } exp_t;

    typedef struct {
        logic          id;
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic          drop;
        logic          strobe;
        logic [2:0]    addr;
        logic [DW-1:0] shadow;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse retires the oldest expected transaction
    initial begin
        int            cyc = 0;
        int            strobe_cnt = 0;
        int            strobe_cyc = 0;
        logic [2:0]    s_addr = '0;
        logic [DW-1:0] s_data = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                strobe_cnt = 0;
            end else begin
                cyc++;
                if (bus.avm_chipselect && !bus.avm_write_n) begin
                    strobe_cnt++;
                    s_addr     = bus.avm_address;
                    s_data     = bus.avm_writedata;
                    strobe_cyc = cyc;
                end
                if (bus.req0_ready || bus.req1_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ready_id", {62'd0, bus.req1_ready, bus.req0_ready}, e.id ? 64'd2 : 64'd1);
                        chk("strobe_count", 64'(strobe_cnt), {63'd0, e.strobe});
                        if (e.strobe) begin
                            chk("bus_addr", {61'd0, s_addr}, {61'd0, e.addr});
                            chk("bus_data", 64'(s_data), 64'(e.data));
                            chk("write_to_ready_latency", 64'(cyc - strobe_cyc), 64'(LAT));
                        end
                        chk("shadow", 64'(bus.shadow), 64'(e.shadow));
                        chk("pio_eq_shadow", 64'(pio_q), 64'(e.shadow));
                    end
                    strobe_cnt = 0;
                end
            end
        end
    end

    task automatic drive(input logic id, input logic v, input logic [1:0] op, input logic [DW-1:0] d);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_data = d;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_data = d;
        end
    endtask

    task automatic wait_ready(input logic id, input logic drop, input logic [1:0] op,
                              input logic [DW-1:0] d, output logic got);
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
            else if (drop && k == 2) drive(id, 1'b0, op, ~d);
        end
        chk("ready_seen", {63'd0, got}, 64'd1);
    endtask

    task automatic do_req(input logic id, input logic [1:0] op, input logic [DW-1:0] d, input logic drop);
        logic got;
        drive(id, 1'b1, op, d);
        wait_ready(id, drop, op, d, got);
        drive(id, 1'b0, op, d);
    endtask

    task automatic req_stream(input logic id, input logic [1:0] op_a, input logic [DW-1:0] d_a,
                              input logic [1:0] op_b, input logic [DW-1:0] d_b);
        logic got;
        drive(id, 1'b1, op_a, d_a);
        wait_ready(id, 1'b0, op_a, d_a, got);
        drive(id, 1'b1, op_b, d_b);
        wait_ready(id, 1'b0, op_b, d_b, got);
        drive(id, 1'b0, op_b, d_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        drive(1'b0, 1'b0, 2'd0, '0);
        drive(1'b1, 1'b0, 2'd0, '0);
        bus.err_clr = 1'b0;

        tbl[0] = '{1'b0, OP_WRITE, 32'h0000_00FF, 1'b0, 1'b1, ADDR_DATA, 32'h0000_00FF};
        tbl[1] = '{1'b1, OP_SET,   32'h0000_0F00, 1'b0, 1'b1, ADDR_SET,  32'h0000_0FFF};
        tbl[2] = '{1'b1, OP_CLEAR, 32'h0000_000F, 1'b0, 1'b1, ADDR_CLR,  32'h0000_0FF0};
        tbl[3] = '{1'b0, OP_NOP,   32'h0000_1234, 1'b0, 1'b0, ADDR_DATA, 32'h0000_0FF0};
        tbl[4] = '{1'b1, OP_WRITE, 32'hA5A5_0000, 1'b1, 1'b1, ADDR_DATA, 32'hA5A5_0000};
        tbl[5] = '{1'b0, OP_SET,   32'h0000_5A5A, 1'b0, 1'b1, ADDR_SET,  32'hA5A5_5A5A};
        tbl[6] = '{1'b0, OP_CLEAR, 32'hFFFF_0000, 1'b0, 1'b1, ADDR_CLR,  32'h0000_5A5A};

        repeat (3) @(negedge clk);
        chk("rst_chipselect", {63'd0, bus.avm_chipselect}, 64'd0);
        chk("rst_write_n",    {63'd0, bus.avm_write_n},    64'd1);
        chk("rst_address",    {61'd0, bus.avm_address},    64'd0);
        chk("rst_writedata",  64'(bus.avm_writedata),      64'd0);
        chk("rst_shadow",     64'(bus.shadow),             64'd0);
        chk("rst_busy",       {63'd0, bus.busy},           64'd0);
        chk("rst_ready",      {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        chk("rst_err",        {63'd0, bus.err_mismatch},   64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sb.push_back('{tbl[i].id, tbl[i].strobe, tbl[i].addr, tbl[i].data, tbl[i].shadow});
            do_req(tbl[i].id, tbl[i].op, tbl[i].data, tbl[i].drop);
        end
        @(negedge clk);
        chk("idle_after_table", {63'd0, bus.busy}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Reset during SETTLE: strobes drop at once, no ready, shadow cleared
        drive(1'b0, 1'b1, OP_WRITE, 32'h0000_ABCD);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.avm_chipselect && !bus.avm_write_n) seen = 1'b1;
        end
        chk("midreset_strobe_seen", {63'd0, seen}, 64'd1);
        repeat (2) @(negedge clk);
        chk("midreset_shadow_before", 64'(bus.shadow), 64'h0000_ABCD);
        reset_n = 1'b0;
        #1;
        chk("midreset_chipselect", {63'd0, bus.avm_chipselect}, 64'd0);
        chk("midreset_write_n",    {63'd0, bus.avm_write_n},    64'd1);
        chk("midreset_shadow",     64'(bus.shadow),             64'd0);
        chk("midreset_busy",       {63'd0, bus.busy},           64'd0);
        drive(1'b0, 1'b0, OP_WRITE, 32'h0000_ABCD);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (SETTLE + 6) @(negedge clk);
        chk("midreset_no_ready_busy", {63'd0, bus.busy}, 64'd0);

        // Continuous contention right after reset: req0, req1, req0, req1
        sb.push_back('{1'b0, 1'b1, ADDR_DATA, 32'h0000_0011, 32'h0000_0011});
        sb.push_back('{1'b1, 1'b1, ADDR_SET,  32'h0000_2200, 32'h0000_2211});
        sb.push_back('{1'b0, 1'b1, ADDR_SET,  32'h0000_0100, 32'h0000_2311});
        sb.push_back('{1'b1, 1'b1, ADDR_CLR,  32'h0000_0011, 32'h0000_2300});
        fork
            req_stream(1'b0, OP_WRITE, 32'h0000_0011, OP_SET,   32'h0000_0100);
            req_stream(1'b1, OP_SET,   32'h0000_2200, OP_CLEAR, 32'h0000_0011);
        join
        repeat (2) @(negedge clk);
        chk("contention_drained", 64'(sb.size()), 64'd0);

        // Readback check with bit 0 stuck low in the PIO model
        stuck_en = 1'b1;
        sb.push_back('{1'b0, 1'b1, ADDR_DATA, 32'h0000_0001, 32'h0000_0001});
        do_req(1'b0, OP_WRITE, 32'h0000_0001, 1'b0);
        chk("err_after_write", {63'd0, bus.err_mismatch}, 64'(VX));
        repeat (3) @(negedge clk);
        chk("err_sticky", {63'd0, bus.err_mismatch}, 64'(VX));
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", {63'd0, bus.err_mismatch}, 64'd0);
        stuck_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
